// File: rtl/descriptor_fetcher_pkg.sv
// Shared definitions for the descriptor fetcher.
// Contents:
//   state_t        - fetcher FSM states
//   *_BIT          - bit positions of the flag fields inside descriptor words
//   LEN_W          - width of the length field in word 1
//   DESC_WORDS     - number of 32-bit words per descriptor
//   writeback_word - status word written back to descriptor word 3
package descriptor_fetcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CHECK,
        ST_PRESENT,
        ST_WAIT_DONE,
        ST_WRITEBACK
    } state_t;

    localparam int OWN_BIT    = 31;
    localparam int DONE_BIT   = 30;
    localparam int EOP_BIT    = 16;
    localparam int LEN_W      = 16;
    localparam int DESC_WORDS = 4;

    // Completion status: OWN cleared (hands the descriptor back to software),
    // DONE set, consumed length in the low bits.
    function automatic logic [31:0] writeback_word(input logic [LEN_W-1:0] len);
        logic [31:0] w;
        w              = '0;
        w[DONE_BIT]    = 1'b1;
        w[LEN_W-1:0]   = len;
        return w;
    endfunction

endpackage

// File: rtl/descriptor_fetcher.sv
// Descriptor chain walker.
// Reads 4-word descriptors from a 1-cycle-latency Avalon-MM memory, hands
// owned descriptors to a consumer, writes the completion status back into
// word 3 and follows the next pointer until a descriptor with OWN=0 is found.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   start, head_ptr            - start pulse and first descriptor word address
//   busy, chain_end            - walking indicator, end-of-chain pulse
//   mem_*                      - Avalon-MM master to the descriptor memory
//   desc_valid/desc_ready      - descriptor handoff (buf addr, length, eop)
//   done_valid/done_ready      - completion report with consumed length
module descriptor_fetcher
    import descriptor_fetcher_pkg::*;
#(
    parameter int                MEM_AW    = 10,
    parameter logic [MEM_AW-1:0] DESC_BASE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MEM_AW-1:0] head_ptr,
    output logic              busy,
    output logic              chain_end,
    output logic [MEM_AW-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [31:0]       desc_buf_addr,
    output logic [15:0]       desc_length,
    output logic              desc_eop,
    input  logic              done_valid,
    output logic              done_ready,
    input  logic [15:0]       done_length
);

    state_t            state_reg;
    logic [2:0]        cnt_reg;
    logic [MEM_AW-1:0] ptr_reg;
    logic [31:0]       words [DESC_WORDS];
    logic [MEM_AW-1:0] start_ptr;
    logic [MEM_AW-1:0] next_ptr;
    logic              unused_bits;

    assign mem_clken      = 1'b1;
    assign mem_byteenable = 4'hF;

    // Descriptors are 4-word aligned; the low pointer bits are always dropped.
    assign start_ptr = {head_ptr[MEM_AW-1:2], 2'b00};
    assign next_ptr  = {words[2][MEM_AW-1:2], 2'b00};

    assign unused_bits = ^{head_ptr[1:0], words[2][31:MEM_AW], words[2][1:0],
                           words[3][OWN_BIT-1:0], words[1][31:EOP_BIT+1]};

    // Word gi arrives on mem_readdata one cycle after its read was issued,
    // i.e. in FETCH cycle gi+1.
    genvar gi;
    generate
        for (gi = 0; gi < DESC_WORDS; gi++) begin : g_word
            logic [31:0] word_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (state_reg == ST_FETCH && cnt_reg == 3'(gi + 1)) begin
                    word_reg <= mem_readdata;
                end
            end
            assign words[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            ptr_reg        <= DESC_BASE;
            busy           <= 1'b0;
            chain_end      <= 1'b0;
            desc_valid     <= 1'b0;
            done_ready     <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_writedata  <= '0;
            desc_buf_addr  <= '0;
            desc_length    <= '0;
            desc_eop       <= 1'b0;
        end else begin
            chain_end <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        ptr_reg        <= start_ptr;
                        mem_address    <= start_ptr;
                        mem_chipselect <= 1'b1;
                        mem_write      <= 1'b0;
                        cnt_reg        <= '0;
                        busy           <= 1'b1;
                        state_reg      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // cnt 0..3 issue reads, cnt 1..4 capture words.
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg < 3'd3) begin
                        mem_address <= {ptr_reg[MEM_AW-1:2], cnt_reg[1:0] + 2'd1};
                    end else begin
                        mem_chipselect <= 1'b0;
                    end
                    if (cnt_reg == 3'd4) begin
                        // Word 3 is on the bus now, so the end pulse lines up
                        // with the CHECK cycle.
                        chain_end <= ~mem_readdata[OWN_BIT];
                        state_reg <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!words[3][OWN_BIT]) begin
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        desc_buf_addr <= words[0];
                        desc_length   <= words[1][LEN_W-1:0];
                        desc_eop      <= words[1][EOP_BIT];
                        desc_valid    <= 1'b1;
                        state_reg     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (desc_ready) begin
                        desc_valid <= 1'b0;
                        done_ready <= 1'b1;
                        state_reg  <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_valid) begin
                        done_ready     <= 1'b0;
                        mem_address    <= {ptr_reg[MEM_AW-1:2], 2'b11};
                        mem_writedata  <= writeback_word(done_length);
                        mem_chipselect <= 1'b1;
                        mem_write      <= 1'b1;
                        state_reg      <= ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    // The write happens this cycle; the first read of the next
                    // descriptor is set up for the following one.
                    ptr_reg        <= next_ptr;
                    mem_address    <= next_ptr;
                    mem_write      <= 1'b0;
                    mem_chipselect <= 1'b1;
                    cnt_reg        <= '0;
                    state_reg      <= ST_FETCH;
                end
                default: begin
                    busy           <= 1'b0;
                    mem_chipselect <= 1'b0;
                    mem_write      <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_descriptor_fetcher.sv
// Scoreboard bench for descriptor_fetcher: a chain-walking reference model
// predicts memory reads, descriptor handoffs, writebacks and chain ends; a
// negedge monitor compares DUT activity against the expected queue.
module tb_descriptor_fetcher;

    localparam int EV_READ  = 0;
    localparam int EV_WRITE = 1;
    localparam int EV_DESC  = 2;
    localparam int EV_END   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  head_ptr;
    logic        busy, chain_end;
    logic [9:0]  mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        desc_valid, desc_ready;
    logic [31:0] desc_buf_addr;
    logic [15:0] desc_length;
    logic        desc_eop;
    logic        done_valid, done_ready;
    logic [15:0] done_length;

    always #5 clk = ~clk;

    descriptor_fetcher #(.MEM_AW(10), .DESC_BASE(10'h000)) dut (
        .clk(clk), .reset(reset), .start(start), .head_ptr(head_ptr),
        .busy(busy), .chain_end(chain_end),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_buf_addr(desc_buf_addr), .desc_length(desc_length), .desc_eop(desc_eop),
        .done_valid(done_valid), .done_ready(done_ready), .done_length(done_length)
    );

    // ---------------- memory (1024x32, 1-cycle read latency) ----------------
    logic [31:0] tb_mem [1024];
    logic [31:0] ref_mem [1024];
    logic        bd_we, bd_clear;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_clear) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'h0;
        end else if (bd_we) begin
            tb_mem[bd_addr] <= bd_data;
        end else if (mem_chipselect && mem_write && mem_byteenable == 4'hF) begin
            tb_mem[mem_address] <= mem_writedata;
        end
        if (mem_chipselect && !mem_write) mem_readdata <= tb_mem[mem_address];
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
    } ev_t;

    ev_t         sb_q[$];
    logic [15:0] done_len_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en;
    int          stall_left;
    bit          block_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [31:0] a, input logic [31:0] b, input logic c);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c;
        sb_q.push_back(e);
    endtask

    task automatic pop_ev(input string name, output ev_t e, output bit ok);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=unexpected_event required=no_event", name);
            ok = 1'b0;
            e.kind = -1; e.a = '0; e.b = '0; e.c = 1'b0;
        end else begin
            e  = sb_q.pop_front();
            ok = 1'b1;
        end
    endtask

    // Reference model: walk the chain over ref_mem using the descriptor rules.
    task automatic model(input logic [9:0] head, input int fixed_len);
        logic [9:0]  p;
        logic [15:0] len;
        logic [31:0] wb;
        p = head & 10'h3FC;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 4; k++) push_ev(EV_READ, 32'(p + 10'(k)), 32'h0, 1'b0);
            if (ref_mem[p + 10'd3][31] == 1'b0) begin
                push_ev(EV_END, 32'h0, 32'h0, 1'b0);
                return;
            end
            push_ev(EV_DESC, ref_mem[p], {16'h0, ref_mem[p + 10'd1][15:0]}, ref_mem[p + 10'd1][16]);
            len = (fixed_len >= 0) ? 16'(fixed_len) : 16'($urandom);
            done_len_q.push_back(len);
            wb = 32'h4000_0000 | {16'h0, len};
            push_ev(EV_WRITE, 32'(p + 10'd3), wb, 1'b0);
            ref_mem[p + 10'd3] = wb;
            p = ref_mem[p + 10'd2][9:0] & 10'h3FC;
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic [15:0] prev_len;
    logic        prev_eop;

    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (mon_en && !reset) begin
            if (mem_chipselect) begin
                pop_ev("mem_access", e, ok);
                if (ok) begin
                    if (!mem_write) begin
                        check("read_kind", e.kind, EV_READ);
                        check("read_addr", {22'h0, mem_address}, e.a);
                    end else begin
                        check("write_kind", e.kind, EV_WRITE);
                        check("write_addr", {22'h0, mem_address}, e.a);
                        check("write_data", mem_writedata, e.b);
                        check("write_be", {28'h0, mem_byteenable}, 32'hF);
                    end
                end
            end
            if (desc_valid) begin
                check("no_mem_in_present", {31'h0, mem_chipselect}, 32'h0);
                if (prev_stall) begin
                    check("stall_addr_stable", desc_buf_addr, prev_addr);
                    check("stall_len_stable", {16'h0, desc_length}, {16'h0, prev_len});
                    check("stall_eop_stable", {31'h0, desc_eop}, {31'h0, prev_eop});
                end
            end
            if (desc_valid && desc_ready) begin
                pop_ev("desc_handoff", e, ok);
                if (ok) begin
                    check("desc_kind", e.kind, EV_DESC);
                    check("desc_addr", desc_buf_addr, e.a);
                    check("desc_len", {16'h0, desc_length}, e.b);
                    check("desc_eop", {31'h0, desc_eop}, {31'h0, e.c});
                end
            end
            if (chain_end) begin
                pop_ev("chain_end", e, ok);
                if (ok) check("end_kind", e.kind, EV_END);
            end
            if (done_valid && done_ready && done_len_q.size() > 0) void'(done_len_q.pop_front());
        end
        prev_stall = desc_valid && !desc_ready;
        prev_addr  = desc_buf_addr;
        prev_len   = desc_length;
        prev_eop   = desc_eop;
    end

    // ---------------- consumer ----------------
    initial begin
        desc_ready  = 1'b0;
        done_valid  = 1'b0;
        done_length = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                desc_ready = 1'b0;
                if (desc_valid) stall_left--;
            end else begin
                desc_ready = 1'($urandom_range(1));
            end
            if (block_done || done_len_q.size() == 0) begin
                done_valid = 1'b0;
            end else begin
                done_valid  = 1'($urandom_range(1));
                done_length = done_len_q[0];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        ref_mem[a] = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic clear_mem();
        bd_clear = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        @(posedge clk); #1;
        bd_clear = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_chain_end"}, {31'h0, chain_end}, 32'h0);
        check({tag, "_desc_valid"}, {31'h0, desc_valid}, 32'h0);
        check({tag, "_done_ready"}, {31'h0, done_ready}, 32'h0);
        check({tag, "_chipselect"}, {31'h0, mem_chipselect}, 32'h0);
        check({tag, "_write"}, {31'h0, mem_write}, 32'h0);
        check({tag, "_byteenable"}, {28'h0, mem_byteenable}, 32'hF);
        check({tag, "_clken"}, {31'h0, mem_clken}, 32'h1);
        check({tag, "_address"}, {22'h0, mem_address}, 32'h0);
        check({tag, "_writedata"}, mem_writedata, 32'h0);
        check({tag, "_buf_addr"}, desc_buf_addr, 32'h0);
        check({tag, "_length"}, {16'h0, desc_length}, 32'h0);
        check({tag, "_eop"}, {31'h0, desc_eop}, 32'h0);
    endtask

    task automatic run_chain(input string name, input logic [9:0] head, input int fixed_len,
                             input int extra_start_at, input int budget);
        bit done;
        model(head, fixed_len);
        head_ptr = head; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done  = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (c == extra_start_at) begin
                head_ptr = 10'h200; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (sb_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check({name, "_complete"}, {31'h0, done}, 32'h1);
        check({name, "_sb_empty"}, sb_q.size(), 32'h0);
        $display("chain %s head=%h done=%0d checks=%0d errors=%0d", name, head, done, checks, errors);
        if (!done) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            sb_q.delete();
            done_len_q.delete();
        end
    endtask

    task automatic build_chain(input int n, output logic [9:0] head);
        bit         used [256];
        int         blk[$];
        int         b;
        logic [9:0] base, nxt;
        for (int i = 0; i <= n; i++) begin
            do b = int'($urandom_range(255)); while (used[b]);
            used[b] = 1'b1;
            blk.push_back(b);
        end
        for (int i = 0; i < n; i++) begin
            base = 10'(blk[i] * 4);
            nxt  = 10'(blk[i + 1] * 4);
            wr(base, $urandom);
            wr(base + 10'd1, $urandom);
            wr(base + 10'd2, ($urandom & 32'hFFFF_FC00) | {22'h0, nxt | 10'($urandom_range(3))});
            wr(base + 10'd3, $urandom | 32'h8000_0000);
        end
        wr(10'(blk[n] * 4) + 10'd3, $urandom & 32'h7FFF_FFFF);
        head = 10'(blk[0] * 4) | 10'($urandom_range(3));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [9:0] head;
        bit         seen;
        reset = 1'b1; start = 1'b0; head_ptr = '0;
        bd_we = 1'b0; bd_clear = 1'b0; bd_addr = '0; bd_data = '0;
        mon_en = 1'b1; stall_left = 0; block_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("por");
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic two-descriptor chain with known writeback value.
        clear_mem();
        wr(10'h010, 32'h1234_5678);
        wr(10'h011, 32'h0001_0040);
        wr(10'h012, 32'h0000_0020);
        wr(10'h013, 32'h8000_0000);
        run_chain("basic", 10'h010, 16'h0040, -1, 400);
        check("basic_wb_word", tb_mem[10'h013], 32'h4000_0040);
        check("basic_busy_low", {31'h0, busy}, 32'h0);

        // Unaligned head and a start pulse while busy.
        clear_mem();
        wr(10'h010, 32'hAAAA_0001);
        wr(10'h011, 32'h0000_1234);
        wr(10'h012, 32'h0000_0044);
        wr(10'h013, 32'h8000_0000);
        wr(10'h044, 32'hBBBB_0002);
        wr(10'h045, 32'h0001_0008);
        wr(10'h046, 32'h0000_0080);
        wr(10'h047, 32'hFFFF_FFFF);
        wr(10'h083, 32'h7FFF_FFFF);
        run_chain("unaligned", 10'h013, -1, 3, 400);

        // Consumer stalls 20 cycles with a descriptor presented.
        clear_mem();
        wr(10'h010, 32'h0BAD_F00D);
        wr(10'h011, 32'h0000_0100);
        wr(10'h012, 32'h0000_0020);
        wr(10'h013, 32'h8000_0000);
        stall_left = 20;
        run_chain("stall", 10'h010, -1, -1, 400);

        // Descriptor at the top of memory pointing to 0x000.
        clear_mem();
        wr(10'h3FC, 32'hCAFE_0000);
        wr(10'h3FD, 32'h0001_0010);
        wr(10'h3FE, 32'h0000_0000);
        wr(10'h3FF, 32'h8000_0000);
        run_chain("wrap", 10'h3FC, -1, -1, 400);

        // Self-loop: writeback clears OWN so the second visit ends the chain.
        clear_mem();
        wr(10'h100, 32'h5555_5555);
        wr(10'h101, 32'h0000_0777);
        wr(10'h102, 32'h0000_0100);
        wr(10'h103, 32'h8000_0000);
        run_chain("selfloop", 10'h100, -1, -1, 400);
        check("selfloop_own_cleared", {31'h0, tb_mem[10'h103][31]}, 32'h0);

        // Random chains.
        for (int r = 0; r < 8; r++) begin
            clear_mem();
            build_chain(int'($urandom_range(1, 5)), head);
            run_chain("random", head, -1, -1, 1500);
        end

        // Reset while waiting for the completion report.
        clear_mem();
        wr(10'h010, 32'h1111_2222);
        wr(10'h011, 32'h0000_0040);
        wr(10'h012, 32'h0000_0020);
        wr(10'h013, 32'h8000_0000);
        block_done = 1'b1;
        mon_en     = 1'b0;
        head_ptr = 10'h010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (done_ready) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reach_wait_done", {31'h0, seen}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_writeback", tb_mem[10'h013], 32'h8000_0000);
        $display("reset_in_wait_done word013=%h", tb_mem[10'h013]);
        block_done = 1'b0;
        sb_q.delete();
        done_len_q.delete();
        mon_en = 1'b1;
        run_chain("after_reset", 10'h010, -1, -1, 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
